multicycle_ctrl: RTL

Main control FSM for the multi-cycle CPU datapath. It decodes the instruction opcode and steps the shared datapath through fetch, decode, execute, memory and write-back cycles. Each cycle it drives the mux selects, write strobes and the 2-bit ALU operation class; the existing ALU-control decoder turns that class into the 3-bit ALU control. Memory accesses stall on a `mem_ready` handshake, so one unified memory can serve both instruction and data accesses.

---
 rtl/cpu_ctrl_pkg.sv | 41 ++++
 rtl/multicycle_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle CPU control path.
// Holds the FSM state enum, opcode values and datapath select encodings.
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      StIdle    = 4'd0,
      StFetch   = 4'd1,
      StDecode  = 4'd2,
      StMemAdr  = 4'd3,
      StMemRd   = 4'd4,
      StMemWb   = 4'd5,
      StMemWr   = 4'd6,
      StRtypeEx = 4'd7,
      StRtypeWb = 4'd8,
      StBeq     = 4'd9,
      StAddiEx  = 4'd10,
      StAddiWb  = 4'd11,
      StJump    = 4'd12
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle CPU: sequences fetch/decode/execute/memory/write-back
// and drives the datapath selects and strobes, stalling memory states on mem_ready.
module multicycle_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned OP_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [OP_W-1:0] op,
   input  logic            mem_ready,
   output logic            pc_write,
   output logic            pc_write_cond,
   output logic            i_or_d,
   output logic            mem_read,
   output logic            mem_write,
   output logic            ir_write,
   output logic            mem_to_reg,
   output logic            reg_dst,
   output logic            reg_write,
   output logic            alu_src_a,
   output logic [1:0]      alu_src_b,
   output logic [1:0]      alu_op,
   output logic [1:0]      pc_src,
   output logic            illegal_op
);

   state_e state_q, state_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = StFetch;
      case (state_q)
         StIdle:    state_d = StFetch;
         StFetch:   state_d = mem_ready ? StDecode : StFetch;
         StDecode: begin
            if (op == OP_W'(OP_LW) || op == OP_W'(OP_SW)) begin
               state_d = StMemAdr;
            end else if (op == OP_W'(OP_RTYPE)) begin
               state_d = StRtypeEx;
            end else if (op == OP_W'(OP_BEQ)) begin
               state_d = StBeq;
            end else if (op == OP_W'(OP_ADDI)) begin
               state_d = StAddiEx;
            end else if (op == OP_W'(OP_J)) begin
               state_d = StJump;
            end else begin
               state_d = StFetch;
            end
         end
         StMemAdr:  state_d = (op == OP_W'(OP_LW)) ? StMemRd : StMemWr;
         StMemRd:   state_d = mem_ready ? StMemWb : StMemRd;
         StMemWb:   state_d = StFetch;
         StMemWr:   state_d = mem_ready ? StFetch : StMemWr;
         StRtypeEx: state_d = StRtypeWb;
         StRtypeWb: state_d = StFetch;
         StBeq:     state_d = StFetch;
         StAddiEx:  state_d = StAddiWb;
         StAddiWb:  state_d = StFetch;
         StJump:    state_d = StFetch;
         default:   state_d = StFetch;
      endcase
   end

   // Output decode; everything not named for a state stays 0
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_B;
      alu_op        = ALUOP_ADD;
      pc_src        = PCSRC_ALU;
      illegal_op    = 1'b0;
      case (state_q)
         StFetch: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            // IR and PC load only on the cycle the fetch actually completes
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         StDecode: begin
            alu_src_b = SRCB_IMM_SH2;
            if (!(op == OP_W'(OP_LW) || op == OP_W'(OP_SW) || op == OP_W'(OP_RTYPE) ||
                  op == OP_W'(OP_BEQ) || op == OP_W'(OP_ADDI) || op == OP_W'(OP_J))) begin
               illegal_op = 1'b1;
            end
         end
         StMemAdr: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         StMemRd: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         StMemWb: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         StMemWr: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         StRtypeEx: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNCT;
         end
         StRtypeWb: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         StBeq: begin
            alu_src_a     = 1'b1;
            alu_op        = ALUOP_SUB;
            pc_write_cond = 1'b1;
            pc_src        = PCSRC_ALUOUT;
         end
         StAddiEx: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         StAddiWb: begin
            reg_write = 1'b1;
         end
         StJump: begin
            pc_write = 1'b1;
            pc_src   = PCSRC_JUMP;
         end
         default: ;
      endcase
   end

endmodule
